// File: rtl/counter_pkg.sv
// Shared encodings and sizing helper for the up/down counter and its prescaler.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // Prescaler counter width; never narrower than one bit.
    function automatic int presc_w(input int prescale);
        return (prescale > 2) ? $clog2(prescale) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Divides enabled cycles by PRESCALE, producing a one-cycle tick; clr restarts the division.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int PW = presc_w(PRESCALE);
    localparam logic [PW-1:0] PLAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pcnt_q, pcnt_d;

    // With PRESCALE=1 PLAST is 0, pcnt never leaves 0 and tick reduces to en.
    assign tick = en && (pcnt_q == PLAST);

    always_comb begin
        pcnt_d = pcnt_q;
        if (clr)
            pcnt_d = '0;
        else if (tick)
            pcnt_d = '0;
        else if (en)
            pcnt_d = pcnt_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst)
            pcnt_q <= '0;
        else
            pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/sync_updown_counter.sv
// Parametrised synchronous up/down counter with prescaler, load, wrap/saturate,
// terminal-count pulse and sticky overflow flag. All outputs are registered.
module sync_updown_counter
    import counter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MODULUS  = 8,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             sat_mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] CMAX = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   CMOD = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;
    logic             tick;
    logic             at_edge;
    logic             bnd;
    logic [WIDTH-1:0] load_clamped;

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .clr  (load),
        .tick (tick)
    );

    // Compare in WIDTH+1 bits so MODULUS == 2**WIDTH never clamps.
    assign load_clamped = ({1'b0, load_val} < CMOD) ? load_val : CMAX;

    assign at_edge = (up_dn == DIR_UP) ? (cnt_q == CMAX) : (cnt_q == '0);
    // A load on the same edge suppresses the count, so no boundary event either.
    assign bnd     = tick && !load && at_edge;

    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = load_clamped;
        else if (tick) begin
            if (!at_edge)
                cnt_d = (up_dn == DIR_UP) ? cnt_q + WIDTH'(1) : cnt_q - WIDTH'(1);
            else if (sat_mode == MODE_WRAP)
                cnt_d = (up_dn == DIR_UP) ? '0 : CMAX;
        end
    end

    always_comb begin
        tc_d  = bnd;
        ovf_d = ovf_q;
        if (bnd)
            ovf_d = 1'b1;
        else if (clr_ovf)
            ovf_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            tc_q  <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            tc_q  <= tc_d;
            ovf_q <= ovf_d;
        end
    end

    assign q   = cnt_q;
    assign tc  = tc_q;
    assign ovf = ovf_q;

endmodule

// File: tb/tb_sync_updown_counter.sv
// Directed bench: default counter (mod 8, no prescale) and a mod-6 /3-prescaled counter.
module tb_sync_updown_counter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // DUT A: defaults
    logic       a_rst = 1, a_en = 0, a_up = 1, a_sat = 0, a_load = 0, a_clr = 0;
    logic [2:0] a_lv = 0;
    logic [2:0] a_q;
    logic       a_tc, a_ovf;

    sync_updown_counter u_a (
        .clk(clk), .rst(a_rst), .en(a_en), .up_dn(a_up), .sat_mode(a_sat),
        .load(a_load), .load_val(a_lv), .clr_ovf(a_clr),
        .q(a_q), .tc(a_tc), .ovf(a_ovf)
    );

    // DUT B: MODULUS=6, PRESCALE=3
    logic       b_rst = 1, b_en = 0, b_up = 1, b_sat = 0, b_load = 0, b_clr = 0;
    logic [2:0] b_lv = 0;
    logic [2:0] b_q;
    logic       b_tc, b_ovf;

    sync_updown_counter #(.WIDTH(3), .MODULUS(6), .PRESCALE(3)) u_b (
        .clk(clk), .rst(b_rst), .en(b_en), .up_dn(b_up), .sat_mode(b_sat),
        .load(b_load), .load_val(b_lv), .clr_ovf(b_clr),
        .q(b_q), .tc(b_tc), .ovf(b_ovf)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // ---- reset ----
        step(); step();
        check("rst_q",   a_q,   0);
        check("rst_tc",  a_tc,  0);
        check("rst_ovf", a_ovf, 0);

        // ---- 1: count up, wrap ----
        a_rst = 0; a_en = 1; a_up = 1; a_sat = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("up_q%0d", k),  a_q,  k % 8);
            check($sformatf("up_tc%0d", k), a_tc, (k == 8) ? 1 : 0);
            if (k == 7) check("up_ovf_pre", a_ovf, 0);
        end
        check("up_ovf", a_ovf, 1);

        // ---- 2: count down from 0 ----
        a_en = 0; a_load = 1; a_lv = 0;
        step();
        check("ld0_q",   a_q,   0);
        check("ld0_ovf", a_ovf, 1);
        a_load = 0; a_up = 0; a_en = 1;
        step(); check("dn_q7", a_q, 7); check("dn_tc7", a_tc, 1);
        step(); check("dn_q6", a_q, 6); check("dn_tc6", a_tc, 0);
        step(); check("dn_q5", a_q, 5);
        a_en = 0; a_clr = 1;
        step(); check("clr_ovf", a_ovf, 0); check("hold_q", a_q, 5);
        a_clr = 0;

        // ---- 3: saturate at top ----
        a_sat = 1; a_load = 1; a_lv = 6;
        step(); check("sat_ld", a_q, 6);
        a_load = 0; a_en = 1; a_up = 1;
        step(); check("sat_q1", a_q, 7); check("sat_tc1", a_tc, 0);
        step(); check("sat_q2", a_q, 7); check("sat_tc2", a_tc, 1);
        step(); check("sat_q3", a_q, 7); check("sat_tc3", a_tc, 1);
        check("sat_ovf", a_ovf, 1);
        a_clr = 1;  // boundary tick with clear: set wins
        step(); check("setwin_ovf", a_ovf, 1); check("setwin_tc", a_tc, 1);
        a_en = 0;
        step(); check("clr2_ovf", a_ovf, 0); check("clr2_tc", a_tc, 0);
        a_clr = 0;

        // ---- 5: load on a tick cycle suppresses the count ----
        a_sat = 0; a_en = 1; a_load = 1; a_lv = 3;
        step(); check("ldtick_q", a_q, 3); check("ldtick_tc", a_tc, 0);
        a_load = 0;
        step(); check("after_ld_q", a_q, 4);

        // ---- 6: rst mid-count beats load/en ----
        a_load = 1; a_lv = 7;
        step(); check("ld7_q", a_q, 7);
        a_load = 0;
        step(); check("wrap_ovf", a_ovf, 1);
        for (int k = 0; k < 5; k++) step();
        check("pre_rst_q", a_q, 5);
        a_rst = 1; a_load = 1; a_lv = 2;
        step();
        check("midrst_q", a_q, 0); check("midrst_tc", a_tc, 0); check("midrst_ovf", a_ovf, 0);
        a_rst = 0; a_load = 0; a_en = 0;

        // ---- 4: prescaled mod-6 counter ----
        b_rst = 0; b_en = 1; b_up = 1;
        for (int n = 1; n <= 18; n++) begin
            step();
            check($sformatf("ps_q%0d", n),  b_q,  (n / 3) % 6);
            check($sformatf("ps_tc%0d", n), b_tc, (n == 18) ? 1 : 0);
        end
        step();  check("gap_q0", b_q, 0);
        b_en = 0;
        step(); step(); check("gap_hold", b_q, 0);
        b_en = 1;
        step(); check("gap_q1", b_q, 0);
        step(); check("gap_q2", b_q, 1);

        // load clamps and restarts the prescaler
        b_load = 1; b_lv = 7;
        step(); check("clamp_q", b_q, 5);
        b_lv = 2;
        step(); check("ps_ld_q", b_q, 2);
        b_load = 0;
        step(); step(); check("ps_ld_hold", b_q, 2);
        step(); check("ps_ld_tick", b_q, 3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
